// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: decode handshake, next-PC feedback and the
// instruction-memory request/response channel.
interface ifu_if;
    logic        valid_out_idu;
    logic        ready_in_idu;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        npc_valid;
    logic [31:0] npc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    // The fetch unit itself
    modport master (
        output valid_out_idu, pc, inst, imem_req_valid, imem_addr,
        input  ready_in_idu, npc_valid, npc, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, imem_rsp_err
    );

    // Decode stage, write-back side and instruction memory
    modport slave (
        input  valid_out_idu, pc, inst, imem_req_valid, imem_addr,
        output ready_in_idu, npc_valid, npc, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, imem_rsp_err
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one instruction in flight, fetched from imem,
// handed to decode, then parked until write-back supplies the next PC.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifu_if.master       bus,
    output logic        fault,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        REQ,
        WAIT_RSP,
        WAIT_READY,
        WAIT_NPC,
        HALT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        load_inst;
    logic        take_npc;
    logic        set_fault;
    logic        count_fetch;

    // State register; reset restarts fetching from any state, HALT included
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath enables; inputs are only honoured in the state that owns them
    always_comb begin
        state_d     = state_q;
        load_inst   = 1'b0;
        take_npc    = 1'b0;
        set_fault   = 1'b0;
        count_fetch = 1'b0;
        case (state_q)
            REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.imem_rsp_err) begin
                        set_fault = 1'b1;
                        state_d   = HALT;
                    end else begin
                        load_inst = 1'b1;
                        state_d   = WAIT_READY;
                    end
                end
            end
            WAIT_READY: begin
                if (bus.ready_in_idu) begin
                    count_fetch = 1'b1;
                    state_d     = WAIT_NPC;
                end
            end
            WAIT_NPC: begin
                if (bus.npc_valid) begin
                    if (bus.npc[1:0] == 2'b00) begin
                        take_npc = 1'b1;
                        state_d  = REQ;
                    end else begin
                        set_fault = 1'b1;
                        state_d   = HALT;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Architectural registers: PC, captured instruction, sticky fault and retired-fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            fault     <= 1'b0;
            fetch_cnt <= 32'h0;
        end else begin
            if (take_npc) begin
                pc_q <= bus.npc;
            end
            if (load_inst) begin
                inst_q <= bus.imem_rsp_data;
            end
            if (set_fault) begin
                fault <= 1'b1;
            end
            if (count_fetch) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    // Handshake outputs decode registered state only, so no input-to-output paths exist
    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.valid_out_idu  = (state_q == WAIT_READY);
    assign bus.imem_addr      = pc_q;
    assign bus.pc             = pc_q;
    assign bus.inst           = inst_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: each scenario task drives the buses cycle by
// cycle and compares against an expected PC / instruction / count / fault
// model that the bench updates from the fetch rules.
module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        fault;
    logic [31:0] fetch_cnt;

    ifu_if bus();

    ifu #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fault     (fault),
        .fetch_cnt (fetch_cnt)
    );

    int checks;
    int passes;

    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_cnt;
    logic        exp_fault;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ready_in_idu   = 1'b0;
        bus.npc_valid      = 1'b0;
        bus.npc            = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
    endtask

    // One fetch from REQ through the decode handshake, ending in WAIT_NPC
    task automatic fetch(input int req_stall, input logic [31:0] data,
                         input int rsp_delay, input int ready_stall, input bit stray);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i <= req_stall; i++) begin
            if (i > 0) tick();
            checks++;
            if ({bus.imem_req_valid, bus.valid_out_idu} !== 2'b10)
                $display("[TB] FAIL req_phase: got req/valid %b, expected 10", {bus.imem_req_valid, bus.valid_out_idu});
            else passes++;
            checks++;
            if (bus.imem_addr !== exp_pc)
                $display("[TB] FAIL req_addr: got %h, expected %h", bus.imem_addr, exp_pc);
            else passes++;
        end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i <= rsp_delay; i++) begin
            if (i > 0) tick();
            checks++;
            if ({bus.imem_req_valid, bus.valid_out_idu} !== 2'b00)
                $display("[TB] FAIL rsp_wait: got req/valid %b, expected 00", {bus.imem_req_valid, bus.valid_out_idu});
            else passes++;
        end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = 1'b0;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        exp_inst = data;
        if (stray) begin
            bus.npc_valid      = 1'b1;
            bus.npc            = 32'h8000_0010;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_err   = 1'b1;
            tick();
            bus.npc_valid      = 1'b0;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err   = 1'b0;
            checks++;
            if ({bus.imem_req_valid, bus.valid_out_idu, fault} !== 3'b010)
                $display("[TB] FAIL stray_ignored: got req/valid/fault %b, expected 010", {bus.imem_req_valid, bus.valid_out_idu, fault});
            else passes++;
        end
        for (int i = 0; i <= ready_stall; i++) begin
            if (i > 0) tick();
            checks++;
            if ({bus.imem_req_valid, bus.valid_out_idu} !== 2'b01)
                $display("[TB] FAIL valid_held: got req/valid %b, expected 01", {bus.imem_req_valid, bus.valid_out_idu});
            else passes++;
            checks++;
            if ({bus.pc, bus.inst} !== {exp_pc, exp_inst})
                $display("[TB] FAIL pc_inst: got %h/%h, expected %h/%h", bus.pc, bus.inst, exp_pc, exp_inst);
            else passes++;
        end
        bus.ready_in_idu = 1'b1;
        tick();
        bus.ready_in_idu = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if ({bus.imem_req_valid, bus.valid_out_idu} !== 2'b00)
            $display("[TB] FAIL after_handshake: got req/valid %b, expected 00", {bus.imem_req_valid, bus.valid_out_idu});
        else passes++;
        checks++;
        if (fetch_cnt !== exp_cnt)
            $display("[TB] FAIL fetch_cnt: got %h, expected %h", fetch_cnt, exp_cnt);
        else passes++;
    endtask

    // Next-PC pulse while parked in WAIT_NPC
    task automatic send_npc(input logic [31:0] n, input bit stray);
        if (stray) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_err   = 1'b1;
            bus.ready_in_idu   = 1'b1;
            tick();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err   = 1'b0;
            bus.ready_in_idu   = 1'b0;
            checks++;
            if ({bus.imem_req_valid, bus.valid_out_idu, fault, fetch_cnt} !== {3'b000, exp_cnt})
                $display("[TB] FAIL npc_wait_stray: got req/valid/fault %b cnt %h, expected 000 cnt %h",
                         {bus.imem_req_valid, bus.valid_out_idu, fault}, fetch_cnt, exp_cnt);
            else passes++;
        end
        bus.npc_valid = 1'b1;
        bus.npc       = n;
        tick();
        bus.npc_valid = 1'b0;
        bus.npc       = $urandom;
        if (n[1:0] == 2'b00) begin
            exp_pc = n;
            checks++;
            if ({bus.imem_req_valid, bus.valid_out_idu, fault} !== 3'b100)
                $display("[TB] FAIL npc_accept: got req/valid/fault %b, expected 100", {bus.imem_req_valid, bus.valid_out_idu, fault});
            else passes++;
        end else begin
            exp_fault = 1'b1;
            checks++;
            if ({bus.imem_req_valid, bus.valid_out_idu, fault} !== 3'b001)
                $display("[TB] FAIL npc_misaligned: got req/valid/fault %b, expected 001", {bus.imem_req_valid, bus.valid_out_idu, fault});
            else passes++;
        end
        checks++;
        if (bus.imem_addr !== exp_pc)
            $display("[TB] FAIL npc_addr: got %h, expected %h", bus.imem_addr, exp_pc);
        else passes++;
    endtask

    // HALT must ignore every input for a while
    task automatic check_halted(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_req_ready = 1'b1;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = $urandom;
            bus.ready_in_idu   = 1'b1;
            bus.npc_valid      = 1'b1;
            bus.npc            = 32'h8000_0100;
            tick();
            checks++;
            if ({bus.imem_req_valid, bus.valid_out_idu, fault} !== 3'b001)
                $display("[TB] FAIL halted: got req/valid/fault %b, expected 001", {bus.imem_req_valid, bus.valid_out_idu, fault});
            else passes++;
            checks++;
            if ({bus.pc, bus.inst, fetch_cnt} !== {exp_pc, exp_inst, exp_cnt})
                $display("[TB] FAIL halted_regs: got %h/%h/%h, expected %h/%h/%h",
                         bus.pc, bus.inst, fetch_cnt, exp_pc, exp_inst, exp_cnt);
            else passes++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_pc    = RESET_PC;
        exp_inst  = 32'h0;
        exp_cnt   = 32'h0;
        exp_fault = 1'b0;
        checks++;
        if ({bus.imem_req_valid, bus.valid_out_idu, fault} !== 3'b100)
            $display("[TB] FAIL reset_ctrl: got req/valid/fault %b, expected 100", {bus.imem_req_valid, bus.valid_out_idu, fault});
        else passes++;
        checks++;
        if ({bus.pc, bus.imem_addr, bus.inst, fetch_cnt} !== {RESET_PC, RESET_PC, 32'h0, 32'h0})
            $display("[TB] FAIL reset_regs: got pc %h addr %h inst %h cnt %h, expected %h %h 0 0",
                     bus.pc, bus.imem_addr, bus.inst, fetch_cnt, RESET_PC, RESET_PC);
        else passes++;
    endtask

    task automatic test_basic();
        fetch(0, 32'h0000_0093, 0, 0, 1'b0);
        checks++;
        if (fetch_cnt !== 32'd1)
            $display("[TB] FAIL basic_cnt: got %h, expected 1", fetch_cnt);
        else passes++;
    endtask

    task automatic test_backpressure();
        send_npc(exp_pc + 32'd4, 1'b0);
        fetch(0, 32'h0041_0113, 0, 3, 1'b0);
    endtask

    task automatic test_req_stall();
        send_npc(exp_pc + 32'd4, 1'b1);
        fetch(5, 32'h00C0_006F, 2, 1, 1'b0);
    endtask

    task automatic test_npc();
        send_npc(exp_pc + 32'd4, 1'b0);
        fetch(1, 32'hFFDF_F06F, 0, 0, 1'b1);
        send_npc(32'h8000_0010, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h8000_0010)
            $display("[TB] FAIL npc_target: got %h, expected 80000010", bus.imem_addr);
        else passes++;
        fetch(0, 32'h0000_0013, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] n;
        for (int k = 0; k < 25; k++) begin
            n = $urandom;
            n[1:0] = 2'b00;
            send_npc(n, 1'($urandom_range(0, 1)));
            fetch($urandom_range(0, 3), $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_wrap();
        force dut.fetch_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_cnt;
        exp_cnt = 32'hFFFF_FFFE;
        send_npc(exp_pc + 32'd4, 1'b0);
        fetch(0, $urandom, 0, 0, 1'b0);
        send_npc(exp_pc + 32'd4, 1'b0);
        fetch(0, $urandom, 0, 0, 1'b0);
        checks++;
        if (fetch_cnt !== 32'h0)
            $display("[TB] FAIL cnt_wrap: got %h, expected 0", fetch_cnt);
        else passes++;
    endtask

    task automatic test_misaligned();
        send_npc(32'h8000_0002, 1'b0);
        check_halted(4);
        test_reset();
    endtask

    task automatic test_rsp_err();
        fetch(0, 32'h1234_5678, 0, 0, 1'b0);
        send_npc(exp_pc + 32'd8, 1'b0);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        exp_fault = 1'b1;
        checks++;
        if ({bus.imem_req_valid, bus.valid_out_idu, fault} !== 3'b001)
            $display("[TB] FAIL rsp_err: got req/valid/fault %b, expected 001", {bus.imem_req_valid, bus.valid_out_idu, fault});
        else passes++;
        checks++;
        if (bus.inst !== exp_inst)
            $display("[TB] FAIL rsp_err_inst: got %h, expected %h", bus.inst, exp_inst);
        else passes++;
        check_halted(3);
        test_reset();
        fetch(0, 32'h0000_0093, 0, 0, 1'b0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        idle_inputs();
        $display("[TB] starting ifu bench");
        test_reset();
        test_basic();
        test_backpressure();
        test_req_stall();
        test_npc();
        test_random();
        test_wrap();
        test_misaligned();
        test_rsp_err();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
